timer_ctrl: RTL and testbench

Timer unit behind the processor's timer register interface. Holds the 64-bit time base (TBU:TBL), the decrementer (DEC) with auto-reload (DECAR), and the control (TCR) and status (TSR) registers. Derives the fixed-interval (FIT) and watchdog events from time-base bit transitions. Raises interrupt and watchdog-reset requests for the interrupt scheduler. Software writes arrive from write-back as value plus write-enable pairs.

---
 rtl/timer_ctrl_pkg.sv | 27 ++
 rtl/timer_prescaler.sv | 23 ++
 rtl/timer_ctrl.sv | 109 ++++++++++
 tb/tb_timer_ctrl.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/timer_ctrl_pkg.sv
// timer_ctrl_pkg: shared timer register types, bit-select tables and helpers
package timer_ctrl_pkg;
    typedef logic [31:0] timer_t;
    typedef struct packed {
        logic [1:0] wp;
        logic [1:0] wrc;
        logic       wie;
        logic       die;
        logic [1:0] fp;
        logic       fie;
        logic       are;
    } tcr_t;
    typedef struct packed {
        logic       enw;
        logic       wis;
        logic [1:0] wrs;
        logic       dis;
        logic       fis;
    } tsr_t;
    // Entry n is the TBL bit watched when the period field selects n.
    localparam logic [3:0][4:0] FIT_BITS_DEF = {5'd23, 5'd19, 5'd15, 5'd11};
    localparam logic [3:0][4:0] WD_BITS_DEF  = {5'd27, 5'd23, 5'd19, 5'd15};
    localparam logic [1:0] WRC_NONE = 2'b00;
    function automatic logic rise(input timer_t prev, input timer_t next, input logic [4:0] idx);
        return ~prev[idx] & next[idx];
    endfunction
endpackage

// File: rtl/timer_prescaler.sv
// timer_prescaler: divides enabled cycles into a one-cycle tick strobe
//   clk_i, reset_i : clock, async active-high reset
//   tick_en_i      : count enable; counter freezes when low
//   tick_o         : high for one enabled cycle every TB_PRESCALE enabled cycles
module timer_prescaler #(
    parameter int TB_PRESCALE = 1
) (
    input  logic clk_i,
    input  logic reset_i,
    input  logic tick_en_i,
    output logic tick_o
);
    localparam int W = TB_PRESCALE > 1 ? $clog2(TB_PRESCALE) : 1;
    localparam logic [W-1:0] LAST = W'(TB_PRESCALE - 1);
    logic [W-1:0] cnt_q, cnt_d;
    always_comb begin
        tick_o = tick_en_i && cnt_q == LAST;
        cnt_d = !tick_en_i ? cnt_q : tick_o ? '0 : cnt_q + W'(1);
    end
    always_ff @(posedge clk_i or posedge reset_i)
        if (reset_i) cnt_q <= '0;
        else cnt_q <= cnt_d;
endmodule

// File: rtl/timer_ctrl.sv
// timer_ctrl: time base, decrementer, FIT and watchdog timers with TCR/TSR
//   clk_i, reset_i        : clock, async active-high reset
//   tick_en_i             : global timer enable
//   *_i / *_we_i          : software write data and enables (tsr_i is a w1c mask)
//   tbu_o..tsr_o          : register state
//   dec/fit/wd_irq_o      : interrupt requests from status & control
//   wd_rst_req_o          : one-cycle pulse on watchdog expiry with wrc set
module timer_ctrl import timer_ctrl_pkg::*; #(
    parameter int              TB_PRESCALE = 1,
    parameter logic [3:0][4:0] FIT_BITS    = FIT_BITS_DEF,
    parameter logic [3:0][4:0] WD_BITS     = WD_BITS_DEF
) (
    input  logic   clk_i,
    input  logic   reset_i,
    input  logic   tick_en_i,
    input  timer_t tbu_i,
    input  timer_t tbl_i,
    input  timer_t dec_i,
    input  timer_t decar_i,
    input  logic   tbu_we_i,
    input  logic   tbl_we_i,
    input  logic   dec_we_i,
    input  logic   decar_we_i,
    input  tcr_t   tcr_i,
    input  logic   tcr_we_i,
    input  tsr_t   tsr_i,
    input  logic   tsr_we_i,
    output timer_t tbu_o,
    output timer_t tbl_o,
    output timer_t dec_o,
    output timer_t decar_o,
    output tcr_t   tcr_o,
    output tsr_t   tsr_o,
    output logic   dec_irq_o,
    output logic   fit_irq_o,
    output logic   wd_irq_o,
    output logic   wd_rst_req_o
);
    logic        tick;
    timer_t      tbu_q, tbu_d, tbl_q, tbl_d, dec_q, dec_d, decar_q, decar_d;
    tcr_t        tcr_q, tcr_d;
    tsr_t        tsr_q, tsr_d, tsr_set, tsr_clr;
    logic        wd_rst_q, wd_rst_d;
    logic [63:0] tb_inc;
    logic        tb_wr, dec_exp, fit_ev, wd_ev, wd_exp;
    timer_prescaler #(.TB_PRESCALE(TB_PRESCALE)) u_pre (
        .clk_i     (clk_i),
        .reset_i   (reset_i),
        .tick_en_i (tick_en_i),
        .tick_o    (tick)
    );
    always_comb begin
        tb_inc = {tbu_q, tbl_q} + 64'd1;
        // Any time-base write suppresses the tick for both halves, so a
        // lone TBL write never carries into TBU in that cycle.
        tb_wr = tbl_we_i | tbu_we_i;
        tbl_d = tbl_we_i ? tbl_i : (tick && !tb_wr) ? tb_inc[31:0] : tbl_q;
        tbu_d = tbu_we_i ? tbu_i : (tick && !tb_wr) ? tb_inc[63:32] : tbu_q;
        dec_exp = tick && dec_q == 32'd1 && !dec_we_i;
        dec_d = dec_we_i ? dec_i
              : dec_exp ? (tcr_q.are ? decar_q : '0)
              : (tick && dec_q != '0) ? dec_q - 32'd1 : dec_q;
        decar_d = decar_we_i ? decar_i : decar_q;
        // Edges are taken between the current and next TBL, covering both
        // ticks and software writes.
        fit_ev = rise(tbl_q, tbl_d, FIT_BITS[tcr_q.fp]);
        wd_ev = rise(tbl_q, tbl_d, WD_BITS[tcr_q.wp]);
        wd_exp = wd_ev & tsr_q.enw & tsr_q.wis;
        tsr_set.enw = wd_ev & ~tsr_q.enw;
        tsr_set.wis = wd_ev & tsr_q.enw & ~tsr_q.wis;
        tsr_set.wrs = (wd_exp && tsr_q.wrs == WRC_NONE) ? tcr_q.wrc : WRC_NONE;
        tsr_set.dis = dec_exp;
        tsr_set.fis = fit_ev;
        tsr_clr = tsr_we_i ? tsr_i : '0;
        tsr_d = tsr_t'((tsr_q & ~tsr_clr) | tsr_set);
        tcr_d = tcr_we_i ? tcr_i : tcr_q;
        // wrc is sticky once armed; only reset clears it.
        tcr_d.wrc = (tcr_q.wrc != WRC_NONE) ? tcr_q.wrc : tcr_d.wrc;
        wd_rst_d = wd_exp && tcr_q.wrc != WRC_NONE;
    end
    always_ff @(posedge clk_i or posedge reset_i)
        if (reset_i) begin
            tbu_q    <= '0;
            tbl_q    <= '0;
            dec_q    <= '0;
            decar_q  <= '0;
            tcr_q    <= '0;
            tsr_q    <= '0;
            wd_rst_q <= 1'b0;
        end else begin
            tbu_q    <= tbu_d;
            tbl_q    <= tbl_d;
            dec_q    <= dec_d;
            decar_q  <= decar_d;
            tcr_q    <= tcr_d;
            tsr_q    <= tsr_d;
            wd_rst_q <= wd_rst_d;
        end
    assign tbu_o        = tbu_q;
    assign tbl_o        = tbl_q;
    assign dec_o        = dec_q;
    assign decar_o      = decar_q;
    assign tcr_o        = tcr_q;
    assign tsr_o        = tsr_q;
    assign dec_irq_o    = tsr_q.dis & tcr_q.die;
    assign fit_irq_o    = tsr_q.fis & tcr_q.fie;
    assign wd_irq_o     = tsr_q.enw & tsr_q.wis & tcr_q.wie;
    assign wd_rst_req_o = wd_rst_q;
endmodule

// File: tb/tb_timer_ctrl.sv
// tb_timer_ctrl: directed stimulus, per-cycle model compare plus literal checks
module tb_timer_ctrl;
    import timer_ctrl_pkg::*;
    logic   clk_i = 1'b0;
    logic   reset_i = 1'b1;
    logic   tick_en_i = 1'b1;
    timer_t tbu_i = '0, tbl_i = '0, dec_i = '0, decar_i = '0;
    logic   tbu_we_i = 0, tbl_we_i = 0, dec_we_i = 0, decar_we_i = 0;
    tcr_t   tcr_i = '0;
    logic   tcr_we_i = 0;
    tsr_t   tsr_i = '0;
    logic   tsr_we_i = 0;
    timer_t tbu_o, tbl_o, dec_o, decar_o;
    tcr_t   tcr_o;
    tsr_t   tsr_o;
    logic   dec_irq_o, fit_irq_o, wd_irq_o, wd_rst_req_o;
    int     checks = 0, passed = 0;

    timer_ctrl dut (
        .clk_i(clk_i), .reset_i(reset_i), .tick_en_i(tick_en_i),
        .tbu_i(tbu_i), .tbl_i(tbl_i), .dec_i(dec_i), .decar_i(decar_i),
        .tbu_we_i(tbu_we_i), .tbl_we_i(tbl_we_i), .dec_we_i(dec_we_i), .decar_we_i(decar_we_i),
        .tcr_i(tcr_i), .tcr_we_i(tcr_we_i), .tsr_i(tsr_i), .tsr_we_i(tsr_we_i),
        .tbu_o(tbu_o), .tbl_o(tbl_o), .dec_o(dec_o), .decar_o(decar_o),
        .tcr_o(tcr_o), .tsr_o(tsr_o),
        .dec_irq_o(dec_irq_o), .fit_irq_o(fit_irq_o), .wd_irq_o(wd_irq_o),
        .wd_rst_req_o(wd_rst_req_o)
    );

    always #5 clk_i = ~clk_i;

    // Rule-level model: one 64-bit time value, event rules applied in order.
    logic [63:0] m_time;
    logic [31:0] m_dec, m_decar, m_prev_l;
    logic        m_enw, m_wis, m_dis, m_fis, m_rst;
    logic [1:0]  m_wrs, m_wrc, m_wp, m_fp;
    logic        m_wie, m_die, m_fie, m_are, m_fit, m_wd, m_dexp, m_oenw, m_owis;
    logic [1:0]  m_owrs;

    always @(posedge clk_i or posedge reset_i)
        if (reset_i) begin
            m_time = 0; m_dec = 0; m_decar = 0;
            {m_enw, m_wis, m_wrs, m_dis, m_fis, m_rst} = '0;
            {m_wp, m_wrc, m_wie, m_die, m_fp, m_fie, m_are} = '0;
        end else begin
            m_prev_l = m_time[31:0];
            if (tbl_we_i || tbu_we_i) begin
                if (tbl_we_i) m_time[31:0] = tbl_i;
                if (tbu_we_i) m_time[63:32] = tbu_i;
            end else if (tick_en_i) m_time = m_time + 1;
            m_fit = !m_prev_l[FIT_BITS_DEF[m_fp]] && m_time[FIT_BITS_DEF[m_fp]];
            m_wd  = !m_prev_l[WD_BITS_DEF[m_wp]] && m_time[WD_BITS_DEF[m_wp]];
            m_dexp = 0;
            if (dec_we_i) m_dec = dec_i;
            else if (tick_en_i && m_dec == 1) begin
                m_dexp = 1;
                m_dec = m_are ? m_decar : 0;
            end else if (tick_en_i && m_dec != 0) m_dec = m_dec - 1;
            if (decar_we_i) m_decar = decar_i;
            {m_oenw, m_owis, m_owrs} = {m_enw, m_wis, m_wrs};
            if (tsr_we_i) begin
                if (tsr_i.enw) m_enw = 0;
                if (tsr_i.wis) m_wis = 0;
                m_wrs = m_wrs & ~tsr_i.wrs;
                if (tsr_i.dis) m_dis = 0;
                if (tsr_i.fis) m_fis = 0;
            end
            if (m_dexp) m_dis = 1;
            if (m_fit) m_fis = 1;
            m_rst = 0;
            if (m_wd) begin
                if (!m_oenw) m_enw = 1;
                else if (!m_owis) m_wis = 1;
                else begin
                    if (m_owrs == 0) m_wrs = m_wrc;
                    m_rst = m_wrc != 0;
                end
            end
            if (tcr_we_i) begin
                {m_wp, m_wie, m_die, m_fp, m_fie, m_are} =
                    {tcr_i.wp, tcr_i.wie, tcr_i.die, tcr_i.fp, tcr_i.fie, tcr_i.are};
                if (m_wrc == 0) m_wrc = tcr_i.wrc;
            end
        end

    always @(negedge clk_i) begin
        logic [199:0] exp_v, act_v;
        exp_v = {m_time, m_dec, m_decar, m_wp, m_wrc, m_wie, m_die, m_fp, m_fie, m_are,
                 m_enw, m_wis, m_wrs, m_dis, m_fis,
                 m_dis & m_die, m_fis & m_fie, m_enw & m_wis & m_wie, m_rst, 24'd0};
        act_v = {tbu_o, tbl_o, dec_o, decar_o, tcr_o, tsr_o,
                 dec_irq_o, fit_irq_o, wd_irq_o, wd_rst_req_o, 24'd0};
        checks++;
        if (act_v === exp_v) passed++;
        else $display("FAIL model_cmp t=%0t got %h want %h", $time, act_v, exp_v);
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s got %0h want %0h", name, act, exp);
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk_i);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

    initial begin
        cyc(3);
        chk("rst_tbl", tbl_o, 0);
        chk("rst_tsr", tsr_o, 0);
        chk("rst_wdreq", wd_rst_req_o, 0);
        reset_i = 0;
        cyc(3);
        chk("tbl_after_3", tbl_o, 3);
        // decrementer one-shot
        dec_we_i = 1; dec_i = 3; tcr_we_i = 1; tcr_i = '0; tcr_i.die = 1;
        cyc(1); dec_we_i = 0; tcr_we_i = 0;
        chk("dec_load", dec_o, 3);
        cyc(1); chk("dec_2", dec_o, 2);
        cyc(1); chk("dec_1", dec_o, 1); chk("dis_early", tsr_o.dis, 0);
        cyc(1); chk("dec_0", dec_o, 0); chk("dis_set", tsr_o.dis, 1); chk("dec_irq", dec_irq_o, 1);
        cyc(10); chk("dec_hold0", dec_o, 0);
        // auto-reload
        decar_we_i = 1; decar_i = 5; dec_we_i = 1; dec_i = 2;
        tcr_we_i = 1; tcr_i = '0; tcr_i.are = 1; tcr_i.die = 1;
        tsr_we_i = 1; tsr_i = '0; tsr_i.dis = 1;
        cyc(1); decar_we_i = 0; dec_we_i = 0; tcr_we_i = 0; tsr_we_i = 0;
        chk("ar_dec2", dec_o, 2); chk("ar_decar", decar_o, 5); chk("ar_dis0", tsr_o.dis, 0);
        cyc(1); chk("ar_dec1", dec_o, 1);
        cyc(1); chk("ar_reload", dec_o, 5); chk("ar_dis1", tsr_o.dis, 1);
        cyc(1); chk("ar_dec4", dec_o, 4);
        tsr_we_i = 1; tsr_i = '0; tsr_i.dis = 1;
        cyc(1); tsr_we_i = 0;
        chk("w1c_dis", tsr_o.dis, 0); chk("w1c_irq", dec_irq_o, 0);
        // time base carry
        tbu_we_i = 1; tbu_i = 7; tbl_we_i = 1; tbl_i = 32'hFFFF_FFFE;
        cyc(1); tbu_we_i = 0; tbl_we_i = 0;
        chk("tb_load", {tbu_o, tbl_o}, 64'h7_FFFF_FFFE);
        cyc(2); chk("tb_carry", {tbu_o, tbl_o}, 64'h8_0000_0000);
        tick_en_i = 0; tbl_we_i = 1; tbl_i = 32'hFFFF_FFFF;
        cyc(1); tick_en_i = 1; tbl_i = 32'h100;
        cyc(1); tbl_we_i = 0;
        chk("tblwe_nocarry", {tbu_o, tbl_o}, 64'h8_0000_0100);
        // FIT edge vs w1c
        tcr_we_i = 1; tcr_i = '0; tcr_i.fie = 1;
        tbl_we_i = 1; tbl_i = 32'h7FE; tsr_we_i = 1; tsr_i = '1;
        cyc(1); tcr_we_i = 0; tbl_we_i = 0; tsr_we_i = 0;
        chk("fit_pre", tsr_o.fis, 0);
        cyc(1); tsr_we_i = 1; tsr_i = '0; tsr_i.fis = 1;
        cyc(1); tsr_we_i = 0;
        chk("fit_tbl", tbl_o, 32'h800); chk("fit_setwins", tsr_o.fis, 1); chk("fit_irq", fit_irq_o, 1);
        // watchdog sequence
        tick_en_i = 0; tcr_we_i = 1; tcr_i = '0; tcr_i.wie = 1; tcr_i.wrc = 2'b01;
        tsr_we_i = 1; tsr_i = '1; tbl_we_i = 1; tbl_i = 0;
        cyc(1); tcr_we_i = 0; tsr_we_i = 0;
        chk("wd_clear", tsr_o, 0);
        tbl_i = 32'h8000; cyc(1);
        chk("wd_enw", {tsr_o.enw, tsr_o.wis}, 2'b10);
        tbl_i = 0; cyc(1); tbl_i = 32'h8000; cyc(1);
        chk("wd_wis", {tsr_o.enw, tsr_o.wis}, 2'b11); chk("wd_irq", wd_irq_o, 1);
        chk("wd_noreq", wd_rst_req_o, 0);
        tbl_i = 0; cyc(1); tbl_i = 32'h8000; cyc(1);
        chk("wd_wrs", tsr_o.wrs, 1); chk("wd_req", wd_rst_req_o, 1);
        tbl_i = 0; cyc(1); tbl_we_i = 0;
        chk("wd_req_pulse", wd_rst_req_o, 0);
        tcr_we_i = 1; tcr_i = '0; tcr_i.wie = 1;
        cyc(1); tcr_we_i = 0;
        chk("wrc_sticky", tcr_o.wrc, 1);
        // async reset mid-count
        tick_en_i = 1; cyc(2);
        #2 reset_i = 1;
        #1 chk("ares_tb", {tbu_o, tbl_o}, 0); chk("ares_tcr", tcr_o, 0); chk("ares_dec", dec_o, 0);
        cyc(2); reset_i = 0;
        cyc(2); chk("post_rst_tbl", tbl_o, 2);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
